// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared widths and configuration-FSM state encoding for the
//               DDS phase-accumulator front end.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int ACC_W_DEF   = 32;
    localparam int ADDR_W_DEF  = 14;
    localparam int ROM_LAT_DEF = 1;

    // Configuration FSM state encoding
    typedef logic [1:0] cfg_state_t;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PEND_IMM  = 2'd1;
    localparam logic [1:0] ST_PEND_WRAP = 2'd2;

endpackage : dds_pkg
`default_nettype wire

// File: rtl/dds_flag_delay.sv
`default_nettype none
// ============================================================================
// Module      : dds_flag_delay
// Description : ROM_LAT-deep shift register carrying {valid, wrap} so the
//               flags line up with the wave-ROM output data.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_flag_delay #(
    parameter int ROM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] d,
    output logic [1:0] q
);

    // Stage 0 occupies the low two bits; the oldest stage is at the top.
    logic [2*ROM_LAT-1:0] r_line;

    generate
        if (ROM_LAT == 1) begin : g_single
            // Single register stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_line <= '0;
                end else begin
                    r_line <= d;
                end
            end
        end else begin : g_chain
            // Shift new flags in at the bottom, oldest falls out the top
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_line <= '0;
                end else begin
                    r_line <= {r_line[2*ROM_LAT-3:0], d};
                end
            end
        end
    endgenerate

    assign q = r_line[2*ROM_LAT-1 -: 2];

endmodule : dds_flag_delay
`default_nettype wire

// File: rtl/dds_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_acc
// Description : DDS phase accumulator. Produces the wave-ROM address stream
//               from an active tuning word and phase offset, with a
//               single-entry shadow register for immediate or
//               phase-continuous (at wrap) updates, and ROM-aligned flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [ACC_W-1:0]  ftw_in,
    input  logic [ADDR_W-1:0] pow_in,
    input  logic              upd_mode,
    input  logic              cfg_load,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_rej,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              wrap_pulse,
    output logic              q_valid,
    output logic              q_wrap
);

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_ftw_a;
    logic [ADDR_W-1:0] r_pow_a;
    logic [ACC_W-1:0]  r_sh_ftw;
    logic [ADDR_W-1:0] r_sh_pow;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic              r_wrap;
    cfg_state_t        r_state;
    logic              r_done;
    logic              r_rej;

    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic [1:0]        w_q_flags;

    // One extra bit captures the accumulator carry-out (period wrap)
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw_a};
    assign w_carry = w_sum[ACC_W];

    // Accumulator and address register; address uses the pre-increment phase
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_valid <= en;
            r_wrap  <= en & w_carry;
            if (en) begin
                r_acc  <= w_sum[ACC_W-1:0];
                r_addr <= r_acc[ACC_W-1 -: ADDR_W] + r_pow_a;
            end
        end
    end

    // Configuration FSM: shadow load, immediate or at-wrap apply, reject
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ftw_a  <= '0;
            r_pow_a  <= '0;
            r_sh_ftw <= '0;
            r_sh_pow <= '0;
            r_done   <= 1'b0;
            r_rej    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Any load that finds the shadow occupied is dropped, even one
            // arriving on the very edge the pending update is applied.
            r_rej  <= cfg_load & (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        r_sh_ftw <= ftw_in;
                        r_sh_pow <= pow_in;
                        r_state  <= upd_mode ? ST_PEND_WRAP : ST_PEND_IMM;
                    end
                end
                ST_PEND_IMM: begin
                    r_ftw_a <= r_sh_ftw;
                    r_pow_a <= r_sh_pow;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_PEND_WRAP: begin
                    // The accumulator still adds the old word on this edge
                    if (en && w_carry) begin
                        r_ftw_a <= r_sh_ftw;
                        r_pow_a <= r_sh_pow;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dds_flag_delay #(
        .ROM_LAT (ROM_LAT)
    ) u_flag_delay (
        .clk (clock),
        .rst (reset),
        .d   ({r_valid, r_wrap}),
        .q   (w_q_flags)
    );

    assign cfg_busy   = (r_state != ST_IDLE);
    assign cfg_done   = r_done;
    assign cfg_rej    = r_rej;
    assign address    = r_addr;
    assign addr_valid = r_valid;
    assign wrap_pulse = r_wrap;
    assign q_valid    = w_q_flags[1];
    assign q_wrap     = w_q_flags[0];

endmodule : dds_phase_acc
`default_nettype wire

// File: tb/tb_dds_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_phase_acc
// Description : Self-checking bench for dds_phase_acc: behavioural model with
//               per-cycle comparison, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_phase_acc;

    localparam int ACC_W  = 32;
    localparam int ADDR_W = 14;
    localparam int LAT    = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [ACC_W-1:0]  ftw_in = '0;
    logic [ADDR_W-1:0] pow_in = '0;
    logic              upd_mode = 1'b0;
    logic              cfg_load = 1'b0;
    logic              cfg_busy, cfg_done, cfg_rej;
    logic [ADDR_W-1:0] address;
    logic              addr_valid, wrap_pulse, q_valid, q_wrap;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    dds_phase_acc #(
        .ACC_W   (ACC_W),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .ftw_in     (ftw_in),
        .pow_in     (pow_in),
        .upd_mode   (upd_mode),
        .cfg_load   (cfg_load),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_rej    (cfg_rej),
        .address    (address),
        .addr_valid (addr_valid),
        .wrap_pulse (wrap_pulse),
        .q_valid    (q_valid),
        .q_wrap     (q_wrap)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_acc, m_ftw, m_sftw;
    logic [13:0] m_pow, m_spow;
    bit          m_pend, m_mode;
    logic [13:0] e_addr;
    bit          e_valid, e_wrap, e_done, e_rej, e_qv, e_qw;
    bit          hv_v [8];
    bit          hv_w [8];

    always @(posedge clock) begin : p_model
        logic [32:0] sum;
        bit          carry, pend0;
        if (reset) begin
            m_acc = '0; m_ftw = '0; m_sftw = '0; m_pow = '0; m_spow = '0;
            m_pend = 0; m_mode = 0;
            e_addr = '0; e_valid = 0; e_wrap = 0; e_done = 0; e_rej = 0;
            for (int i = 0; i < 8; i++) begin hv_v[i] = 0; hv_w[i] = 0; end
            e_qv = 0; e_qw = 0;
        end else begin
            sum   = {1'b0, m_acc} + {1'b0, m_ftw};
            carry = sum[32];
            pend0 = m_pend;
            // flag history: index k holds the flag as it was k+1 edges ago
            for (int i = 7; i > 0; i--) begin hv_v[i] = hv_v[i-1]; hv_w[i] = hv_w[i-1]; end
            hv_v[0] = e_valid;
            hv_w[0] = e_wrap;
            e_qv = hv_v[LAT-1];
            e_qw = hv_w[LAT-1];
            e_valid = en;
            e_wrap  = en && carry;
            if (en) begin
                e_addr = m_acc[31:18] + m_pow;
                m_acc  = sum[31:0];
            end
            e_rej  = cfg_load && pend0;
            e_done = pend0 && (!m_mode || (en && carry));
            if (e_done) begin
                m_ftw = m_sftw; m_pow = m_spow; m_pend = 0;
            end else if (cfg_load && !pend0) begin
                m_sftw = ftw_in; m_spow = pow_in; m_mode = upd_mode; m_pend = 1;
            end
        end
    end

    // Compare every cycle once the model has been reset alongside the DUT
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("m_address", address, e_addr);
            chk("m_addr_valid", addr_valid, e_valid);
            chk("m_wrap_pulse", wrap_pulse, e_wrap);
            chk("m_q_valid", q_valid, e_qv);
            chk("m_q_wrap", q_wrap, e_qw);
            chk("m_cfg_busy", cfg_busy, m_pend);
            chk("m_cfg_done", cfg_done, e_done);
            chk("m_cfg_rej", cfg_rej, e_rej);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [31:0] f, input logic [13:0] p, input logic m);
        ftw_in = f; pow_in = p; upd_mode = m; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin : p_stim
        logic [13:0] exp3 [4];
        logic [31:0] rv;
        exp3[0] = 14'h3FFE; exp3[1] = 14'h3FFF; exp3[2] = 14'h0000; exp3[3] = 14'h0001;

        repeat (2) tick();
        cmp_on = 1'b1;
        reset  = 1'b0;
        chk("rst_address", address, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_q_valid", q_valid, 0);

        // 1: immediate load, slow ramp
        load(32'h0004_0000, 14'h0, 1'b0);
        chk("t1_busy", cfg_busy, 1);
        chk("t1_done_early", cfg_done, 0);
        tick();
        chk("t1_done", cfg_done, 1);
        chk("t1_busy_clr", cfg_busy, 0);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t1_addr", address, k);
            chk("t1_valid", addr_valid, 1);
            chk("t1_q_valid", q_valid, (k >= LAT) ? 1 : 0);
        end

        // 2: quarter-period steps with wrap
        en = 1'b0;
        do_reset();
        load(32'h4000_0000, 14'h0, 1'b0);
        tick();
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_addr", address, (k % 4) * 32'h1000);
            chk("t2_wrap", wrap_pulse, (k % 4 == 3) ? 1 : 0);
            chk("t2_q_wrap", q_wrap, (k >= LAT && ((k - LAT) % 4 == 3)) ? 1 : 0);
        end

        // 3: phase offset rollover without accumulator wrap
        en = 1'b0;
        do_reset();
        load(32'h0004_0000, 14'h3FFE, 1'b0);
        tick();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_addr", address, exp3[k]);
            chk("t3_wrap", wrap_pulse, 0);
        end

        // 4/5: phase-continuous update with a rejected second load
        en = 1'b0;
        do_reset();
        load(32'h4000_0000, 14'h0, 1'b0);
        tick();
        en = 1'b1;
        tick();
        tick();
        chk("t4_addr_1000", address, 32'h1000);
        load(32'h8000_0000, 14'h0, 1'b1);
        chk("t4_addr_2000", address, 32'h2000);
        chk("t4_busy", cfg_busy, 1);
        chk("t4_done_wait", cfg_done, 0);
        ftw_in = 32'h2000_0000; upd_mode = 1'b0; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("t4_addr_3000", address, 32'h3000);
        chk("t4_wrap", wrap_pulse, 1);
        chk("t4_done", cfg_done, 1);
        chk("t5_rej", cfg_rej, 1);
        tick();
        chk("t4_addr_a", address, 0);
        chk("t5_rej_clr", cfg_rej, 0);
        tick();
        chk("t4_addr_b", address, 32'h2000);
        chk("t4_wrap_b", wrap_pulse, 1);
        tick();
        chk("t4_addr_c", address, 0);

        // 6: reset while an at-wrap update is pending
        en = 1'b0;
        load(32'h4000_0000, 14'h5, 1'b1);
        repeat (3) begin
            tick();
            chk("t6_pending", cfg_busy, 1);
        end
        en = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_addr", address, 0);
        chk("t6_valid", addr_valid, 0);
        chk("t6_busy", cfg_busy, 0);
        chk("t6_done", cfg_done, 0);
        repeat (4) begin
            tick();
            chk("t6_hold", address, 0);
            chk("t6_nodone", cfg_done, 0);
        end

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rv       = $urandom;
            en       = (rv[1:0] != 2'b00);
            cfg_load = (rv[4:2] == 3'b000);
            upd_mode = rv[5];
            reset    = (rv[15:6] == 10'd0);
            rv       = $urandom;
            ftw_in   = rv >> ($urandom % 8);
            rv       = $urandom;
            pow_in   = rv[13:0];
            tick();
        end
        cfg_load = 1'b0;
        en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dds_phase_acc
`default_nettype wire

// File: doc/dds_phase_acc.md
Name: dds_phase_acc

Overview:
Phase-accumulator front end of the DDS. It generates the 14-bit wave-ROM address stream from a 32-bit frequency tuning word (FTW) and a phase offset word (POW). Updates are loaded through a single-entry shadow register, applied either immediately or phase-continuously at the next period wrap. Valid and wrap flags are delay-matched to the ROM read latency so the downstream PWM comparator sees them aligned with the ROM output.

Parameters:
ACC_W, 32, accumulator width
ADDR_W, 14, ROM address width (top ADDR_W bits of accumulator)
ROM_LAT, 1, ROM read latency in clocks, for flag alignment (legal 1..4)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  advance accumulator this cycle
ftw_in  in  ACC_W  new tuning word
pow_in  in  ADDR_W  new phase offset
upd_mode  in  1  sampled with cfg_load: 0 = apply immediately, 1 = apply at wrap
cfg_load  in  1  single-cycle load strobe
cfg_busy  out  1  shadow holds an unapplied update
cfg_done  out  1  one-cycle pulse on the edge the update becomes active
cfg_rej  out  1  one-cycle pulse when cfg_load arrives while busy
address  out  ADDR_W  registered ROM address
addr_valid  out  1  address updated this cycle
wrap_pulse  out  1  address is the last sample of a period
q_valid  out  1  addr_valid delayed ROM_LAT
q_wrap  out  1  wrap_pulse delayed ROM_LAT

Behaviour:
Reset (sync, highest priority) clears:
- acc, ftw_a, pow_a, shadow, address
- all flags and delay-line stages
- state -> IDLE

Reset mid-operation discards any pending update. Power-up active FTW is 0, so a load is required before the output moves.

Datapath, at each edge with en=1:
- acc <= acc + ftw_a, modulo 2^ACC_W
- address <= acc[ACC_W-1 -: ADDR_W] + pow_a, modulo 2^ADDR_W, using the pre-increment acc
- addr_valid <= 1
- wrap_pulse <= carry-out of acc + ftw_a

With en=0:
- acc and address hold
- addr_valid <= 0, wrap_pulse <= 0

Output timing:
- First address after the first enabled edge is pow_a.
- Latency from en to address is 1 clock.
- q_valid and q_wrap equal addr_valid and wrap_pulse delayed by exactly ROM_LAT clocks. They are independent of en in the delay stages.

Config FSM states: IDLE, PEND_IMM, PEND_WRAP.
- IDLE + cfg_load: shadow <= {ftw_in, pow_in}, cfg_busy <= 1, go to PEND_IMM (upd_mode=0) or PEND_WRAP (upd_mode=1).
- PEND_IMM: on the next edge, ftw_a/pow_a <= shadow, cfg_done pulse, cfg_busy <= 0, go to IDLE. Increments use the new values from the following edge onward.
- PEND_WRAP: hold until an edge with en=1 and carry=1. On that edge the accumulator adds the old ftw_a, then ftw_a/pow_a <= shadow, cfg_done pulse, go to IDLE.
- PEND_WRAP with en=0 or ftw_a=0 waits indefinitely. Only reset clears it.

Boundary cases:
- cfg_load in any non-IDLE state: ignored, shadow unchanged, cfg_rej pulses one cycle.
- cfg_load and apply on the same edge: the load is rejected, because the state is not IDLE at that edge.
- cfg_done and wrap_pulse may assert together.

Decomposition:
- Package dds_pkg: ACC_W/ADDR_W defaults and the FSM state enum.
- Sub-module dds_flag_delay: a ROM_LAT-deep shift register for {valid, wrap}, instantiated once.

Test Plan:
1. reset; load ftw=0x00040000, pow=0, upd_mode=0; en=1 -> cfg_done 1 clk after the load; address 0,1,2,3…; addr_valid high; q_valid rises ROM_LAT clocks after addr_valid.
2. ftw=0x40000000 -> address 0x0000,0x1000,0x2000,0x3000 repeating; wrap_pulse high on every 0x3000; q_wrap is the same pattern delayed ROM_LAT.
3. ftw=0x00040000, pow=0x3FFE -> address 0x3FFE,0x3FFF,0x0000,0x0001; wrap_pulse does not assert at the address rollover, because the accumulator has not wrapped.
4. Running ftw=0x40000000 at address 0x1000; load ftw=0x80000000, upd_mode=1 -> 0x2000,0x3000 continue, cfg_done on the wrap edge, then 0x0000,0x2000,0x0000…; cfg_busy high throughout.
5. Second cfg_load while in PEND_WRAP -> cfg_rej one-cycle pulse; the update applied at wrap is the first word.
6. reset asserted while in PEND_WRAP with en=1 -> the next cycle has address=0, all flags 0, cfg_busy=0; with en=1 the address stays 0 until a new load.
